// File: rtl/cam_cfg_sequencer.sv
// Camera configuration sequencer: walks the config ROM from address 0 and
// turns each {reg, value} entry into one SCCB write, with delay and end markers.
module cam_cfg_sequencer #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int DELAY_US    = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic [7:0]  o_rom_addr,
  input  logic [15:0] i_rom_data,
  output logic        o_sccb_valid,
  output logic [7:0]  o_sccb_reg,
  output logic [7:0]  o_sccb_data,
  input  logic        i_sccb_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_wr_count
);

  localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1_000_000 * DELAY_US;
  localparam int CNT_W = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYCLES - 1);

  localparam logic [15:0] ENTRY_END   = 16'hFFFF;
  localparam logic [15:0] ENTRY_DELAY = 16'hFFF0;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, WRITE, DELAY, ADV, DRAIN, DONE
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_dly_cnt;
  logic [7:0]       r_rom_addr;
  logic             r_sccb_valid;
  logic [7:0]       r_sccb_reg;
  logic [7:0]       r_sccb_data;
  logic             r_busy;
  logic             r_done;
  logic [7:0]       r_wr_count;

  assign o_rom_addr   = r_rom_addr;
  assign o_sccb_valid = r_sccb_valid;
  assign o_sccb_reg   = r_sccb_reg;
  assign o_sccb_data  = r_sccb_data;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_wr_count   = r_wr_count;

  // valid/ready: once o_sccb_valid rises, reg/data stay frozen and valid stays
  // high until the first edge with i_sccb_ready=1; that edge is the acceptance.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_dly_cnt    <= '0;
      r_rom_addr   <= '0;
      r_sccb_valid <= 1'b0;
      r_sccb_reg   <= '0;
      r_sccb_data  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            r_state    <= FETCH;
            r_rom_addr <= '0;
            r_wr_count <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        // Registered ROM: data for the new address appears one cycle later.
        FETCH: r_state <= DECODE;
        DECODE: begin
          if (i_rom_data == ENTRY_END) begin
            r_state <= DRAIN;
          end else if (i_rom_data == ENTRY_DELAY) begin
            r_state   <= DELAY;
            r_dly_cnt <= '0;
          end else begin
            r_state      <= WRITE;
            r_sccb_reg   <= i_rom_data[15:8];
            r_sccb_data  <= i_rom_data[7:0];
            r_sccb_valid <= 1'b1;
          end
        end
        WRITE: begin
          if (i_sccb_ready) begin
            r_wr_count   <= r_wr_count + 8'd1;
            r_sccb_valid <= 1'b0;
            r_state      <= ADV;
          end
        end
        DELAY: begin
          if (r_dly_cnt == DELAY_LAST) begin
            r_state <= ADV;
          end else begin
            r_dly_cnt <= r_dly_cnt + 1'b1;
          end
        end
        // Address 255 is the last entry; the pointer never wraps.
        ADV: begin
          if (r_rom_addr == 8'hFF) begin
            r_state <= DRAIN;
          end else begin
            r_rom_addr <= r_rom_addr + 8'd1;
            r_state    <= FETCH;
          end
        end
        DRAIN: begin
          if (i_sccb_ready) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
